// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg: shared types and helpers for the LED sweep monitor.
//   sweep_state_t : tracker phases (IDLE, SYNC, ARM, TRACK)
//   dir_t         : sweep direction, DIR_LEFT = moving toward the MSB
//   isOneHot()    : exactly-one-bit-set test on a zero-extended LED word
// ---------------------------------------------------------------------------
package led_pkg;

   // Widest LED bus isOneHot() accepts; narrower buses are zero-extended.
   localparam int unsigned LED_MAX_W = 256;

   typedef enum logic [1:0] {IDLE, SYNC, ARM, TRACK} sweep_state_t;

   typedef enum logic {DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1} dir_t;

   function automatic logic isOneHot(input logic [LED_MAX_W-1:0] v);
      return (v != '0) && ((v & (v - LED_MAX_W'(1))) == '0);
   endfunction

endpackage

// File: rtl/led_onehot_encoder.sv
// ---------------------------------------------------------------------------
// led_onehot_encoder: combinational one-hot to binary index.
//   leds   in  nLED          LED pattern
//   index  out clog2(nLED)   index of the lit LED (OR of set-bit indices)
//   oneHot out 1             exactly one LED lit
// index is only meaningful when oneHot is high.
// ---------------------------------------------------------------------------
module led_onehot_encoder
   import led_pkg::*;
#(
   parameter int nLED = 8
) (
   input  logic [nLED-1:0]         leds,
   output logic [$clog2(nLED)-1:0] index,
   output logic                    oneHot
);

   localparam int IW = $clog2(nLED);

   always_comb begin
      index = '0;
      for (int i = 0; i < nLED; i++) begin
         if (leds[i]) index = index | IW'(i);
      end
   end

   assign oneHot = isOneHot(LED_MAX_W'(leds));

endmodule

// File: rtl/led_sweep_decoder.sv
// ---------------------------------------------------------------------------
// led_sweep_decoder: watches a bouncing one-hot LED sweep on tick strobes and
// recovers its speed, direction and position.
//   clk, reset     system clock, synchronous active-high reset
//   tick           one-clk sample strobe
//   leds  [nLED]   LED bus
//   speed [nSpeed] 2^nSpeed - period (0 when period >= 2^nSpeed)
//   dirLeft        1 = moving toward MSB
//   position       index of the lit LED at the last update
//   valid          high while tracking
//   update         1-clk pulse, new measurement published
//   err            1-clk pulse, illegal sample seen
//   errCount [8]   saturating err count (only with LED_SWEEP_ERR_CNT_EN)
// Build option: define LED_SWEEP_ERR_CNT_EN to add the errCount output.
// ---------------------------------------------------------------------------
module led_sweep_decoder
   import led_pkg::*;
#(
   parameter int nSpeed = 8,
   parameter int nLED   = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tick,
   input  logic [nLED-1:0]         leds,
   output logic [nSpeed-1:0]       speed,
   output logic                    dirLeft,
   output logic [$clog2(nLED)-1:0] position,
   output logic                    valid,
   output logic                    update,
   output logic                    err
`ifdef LED_SWEEP_ERR_CNT_EN
   ,
   output logic [7:0]              errCount
`endif
);

   localparam int IW = $clog2(nLED);
   localparam int PW = nSpeed + 1;
   localparam logic [PW-1:0] P_MAX = '1;
   localparam logic [IW:0]   LAST  = (IW+1)'(nLED - 1);

   sweep_state_t      state_q, state_d;
   logic [nLED-1:0]   prev_q, prev_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [PW-1:0]     period_q, period_d;
   logic [nSpeed-1:0] speed_q, speed_d;
   dir_t              dir_q, dir_d;
   logic [IW-1:0]     pos_q, pos_d;
   logic              update_q, update_d;
   logic              err_q, err_d;

   logic [IW-1:0]     smp_idx;
   logic              smp_oh;

   led_onehot_encoder #(.nLED(nLED)) u_enc (
      .leds   (leds),
      .index  (smp_idx),
      .oneHot (smp_oh)
   );

   // Indices compared one bit wider so nLED-1 -> 0 can never look adjacent.
   logic [IW:0]       idx_ext, smp_ext;
   logic              step, rising, falling, at_end, rev_ok, legal;
   dir_t              new_dir;
   logic [PW-1:0]     period_inc;
   logic [nSpeed-1:0] meas_speed;

   always_comb begin
      idx_ext    = {1'b0, idx_q};
      smp_ext    = {1'b0, smp_idx};
      step       = (leds != prev_q);
      rising     = (smp_ext == idx_ext + (IW+1)'(1));
      falling    = (smp_ext + (IW+1)'(1) == idx_ext);
      new_dir    = rising ? DIR_LEFT : DIR_RIGHT;
      at_end     = (idx_q == '0) || (idx_ext == LAST);
      // Once tracking, the bar may only turn around at either end.
      rev_ok     = (state_q != TRACK) || (new_dir == dir_q) || at_end;
      legal      = smp_oh && (rising || falling) && rev_ok;
      period_inc = (period_q == P_MAX) ? P_MAX : period_q + PW'(1);
      // 2^nSpeed - P in nSpeed bits is the two's complement of P's low bits.
      meas_speed = period_q[PW-1] ? '0 : (~period_q[nSpeed-1:0] + nSpeed'(1));
   end

   always_comb begin
      state_d  = state_q;
      prev_d   = prev_q;
      idx_d    = idx_q;
      period_d = period_q;
      speed_d  = speed_q;
      dir_d    = dir_q;
      pos_d    = pos_q;
      update_d = 1'b0;
      err_d    = 1'b0;
      if (tick) begin
         prev_d = leds;
         case (state_q)
            IDLE: begin
               if (smp_oh) begin
                  idx_d    = smp_idx;
                  period_d = PW'(1);
                  state_d  = SYNC;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: begin
               if (step) begin
                  if (legal) begin
                     idx_d    = smp_idx;
                     period_d = PW'(1);
                     dir_d    = new_dir;
                     if (state_q == SYNC) begin
                        // First step only fixes direction; its period is partial.
                        state_d = ARM;
                     end else begin
                        state_d  = TRACK;
                        update_d = 1'b1;
                        speed_d  = meas_speed;
                        pos_d    = smp_idx;
                     end
                  end else begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  period_d = period_inc;
                  // Sweep too slow to measure: fall back and re-arm on position.
                  if (state_q != SYNC && period_inc == P_MAX) state_d = SYNC;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         prev_q   <= '0;
         idx_q    <= '0;
         period_q <= '0;
         speed_q  <= '0;
         dir_q    <= DIR_LEFT;
         pos_q    <= '0;
         update_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         idx_q    <= idx_d;
         period_q <= period_d;
         speed_q  <= speed_d;
         dir_q    <= dir_d;
         pos_q    <= pos_d;
         update_q <= update_d;
         err_q    <= err_d;
      end
   end

   assign speed    = speed_q;
   assign dirLeft  = (dir_q == DIR_LEFT);
   assign position = pos_q;
   assign valid    = (state_q == TRACK);
   assign update   = update_q;
   assign err      = err_q;

`ifdef LED_SWEEP_ERR_CNT_EN
   logic [7:0] errcnt_q, errcnt_d;

   always_comb begin
      errcnt_d = errcnt_q;
      if (err_d && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) errcnt_q <= '0;
      else       errcnt_q <= errcnt_d;
   end

   assign errCount = errcnt_q;
`endif

endmodule

// File: tb/tb_led_sweep_decoder.sv
// ---------------------------------------------------------------------------
// tb_led_sweep_decoder: directed bench for led_sweep_decoder (nSpeed=8,
// nLED=8). A behavioural model tracks the sweep as "locked / number of legal
// steps since lock / ticks since last step" and predicts every output each
// clock; literal checks pin key points of the expected behaviour.
// ---------------------------------------------------------------------------
module tb_led_sweep_decoder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic [7:0] leds = 8'h00;
   logic [7:0] speed;
   logic       dirLeft;
   logic [2:0] position;
   logic       valid, update, err;
`ifdef LED_SWEEP_ERR_CNT_EN
   logic [7:0] errCount;
`endif

   always #5 clk = ~clk;

   led_sweep_decoder #(.nSpeed(8), .nLED(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .leds     (leds),
      .speed    (speed),
      .dirLeft  (dirLeft),
      .position (position),
      .valid    (valid),
      .update   (update),
      .err      (err)
`ifdef LED_SWEEP_ERR_CNT_EN
      ,
      .errCount (errCount)
`endif
   );

   int n_chk = 0;
   int n_err = 0;
   int n_upd_seen = 0;
   int n_err_seen = 0;

   // expected outputs
   int   e_speed = 0, e_pos = 0, e_cnt = 0;
   bit   e_dir = 1'b1, e_valid = 1'b0, e_upd = 1'b0, e_err = 1'b0;
   // model of the sweep
   bit         m_locked = 1'b0;
   int         m_nsteps = 0;   // legal steps since lock (capped at 2)
   int         m_gap = 0;      // ticks since last step (saturates at 511)
   int         m_idx = 0;
   logic [7:0] m_prev = 8'h00;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model(input bit rst, input bit tk, input logic [7:0] l);
      int  k, ni;
      bit  ok, left;
      e_upd = 1'b0;
      e_err = 1'b0;
      if (rst) begin
         e_speed = 0; e_pos = 0; e_dir = 1'b1; e_cnt = 0;
         m_locked = 1'b0; m_nsteps = 0; m_gap = 0; m_idx = 0; m_prev = 8'h00;
      end else if (tk) begin
         k  = $countones(l);
         ni = 0;
         for (int i = 0; i < 8; i++) if (l[i]) ni = i;
         if (!m_locked) begin
            if (k == 1) begin
               m_locked = 1'b1; m_nsteps = 0; m_idx = ni; m_gap = 1;
            end else begin
               e_err = 1'b1;
            end
         end else if (l != m_prev) begin
            ok   = (k == 1) && (ni == m_idx + 1 || ni == m_idx - 1);
            left = (ni > m_idx);
            if (ok && m_nsteps >= 2 && left != e_dir && m_idx != 0 && m_idx != 7) ok = 1'b0;
            if (ok) begin
               if (m_nsteps >= 1) begin
                  e_upd   = 1'b1;
                  e_speed = (m_gap >= 256) ? 0 : 256 - m_gap;
                  e_pos   = ni;
               end
               e_dir    = left;
               m_nsteps = (m_nsteps >= 2) ? 2 : m_nsteps + 1;
               m_idx    = ni;
               m_gap    = 1;
            end else begin
               e_err    = 1'b1;
               m_locked = 1'b0;
               m_nsteps = 0;
            end
         end else begin
            if (m_gap < 511) m_gap++;
            if (m_gap == 511 && m_nsteps >= 1) m_nsteps = 0;
         end
         m_prev = l;
      end
      e_valid = m_locked && (m_nsteps >= 2);
      if (e_err && e_cnt < 255) e_cnt++;
   endtask

   // One clock: drive inputs, advance model, then compare after the edge.
   task automatic cyc(input bit rst, input bit tk, input logic [7:0] l);
      reset = rst;
      tick  = tk;
      leds  = l;
      model(rst, tk, l);
      @(posedge clk);
      #1;
      chk("speed", speed, e_speed);
      chk("dirLeft", dirLeft, e_dir);
      chk("position", position, e_pos);
      chk("valid", valid, e_valid);
      chk("update", update, e_upd);
      chk("err", err, e_err);
`ifdef LED_SWEEP_ERR_CNT_EN
      chk("errCount", errCount, e_cnt);
`endif
      if (update === 1'b1) n_upd_seen++;
      if (err === 1'b1) n_err_seen++;
   endtask

   // n ticks of pattern l; gap non-tick cycles after each carry junk on the bus.
   task automatic hold(input logic [7:0] l, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         cyc(1'b0, 1'b1, l);
         for (int j = 0; j < gap; j++) cyc(1'b0, 1'b0, 8'hFF);
      end
   endtask

   int base_u, base_e;
   logic [7:0] pat;

   initial begin
      // reset (tick high on one reset cycle: reset must win)
      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b1, 1'b1, 8'h01);
      cyc(1'b1, 1'b0, 8'h00);
      chk("rst_speed", speed, 0);
      chk("rst_dir", dirLeft, 1);
      chk("rst_valid", valid, 0);
      chk("rst_update", update, 0);

      // static LED: locks but never tracks
      base_u = n_upd_seen; base_e = n_err_seen;
      hold(8'h01, 100, 1);
      chk("static_valid", valid, 0);
      chk("static_updates", n_upd_seen - base_u, 0);
      chk("static_errs", n_err_seen - base_e, 0);

      // sweep up, step every 6 ticks
      hold(8'h02, 6, 0);
      hold(8'h04, 1, 0);
      chk("first_upd", update, 1);
      chk("first_speed", speed, 250);
      chk("first_pos", position, 2);
      chk("first_dir", dirLeft, 1);
      chk("first_valid", valid, 1);
      hold(8'h04, 5, 0);
      pat = 8'h08;
      for (int s = 0; s < 5; s++) begin
         hold(pat, 6, 0);
         pat = pat << 1;
      end
      chk("sweep_updates", n_upd_seen - base_u, 6);

      // bounce off the top end
      hold(8'h40, 1, 0);
      chk("bounce_dir", dirLeft, 0);
      chk("bounce_pos", position, 6);
      chk("bounce_speed", speed, 250);
      chk("bounce_err", err, 0);
      hold(8'h40, 5, 0);
      hold(8'h20, 6, 0);
      hold(8'h10, 6, 0);
      // mid-bar reversal
      hold(8'h20, 1, 0);
      chk("rev_err", err, 1);
      chk("rev_valid", valid, 0);
      chk("rev_dir_hold", dirLeft, 0);

      // fresh start, track with steps every 3 ticks, then non-one-hot
      cyc(1'b1, 1'b0, 8'h00);
      hold(8'h20, 3, 0);
      hold(8'h40, 3, 0);
      hold(8'h80, 3, 0);
      hold(8'h40, 3, 0);
      chk("t2_speed", speed, 253);
      chk("t2_valid", valid, 1);
      hold(8'h03, 1, 0);
      chk("twohot_err", err, 1);
`ifdef LED_SWEEP_ERR_CNT_EN
      chk("errcount_one", errCount, 1);
`endif
      hold(8'h04, 1, 0);
      chk("twohot_err_len", err, 0);
      hold(8'h10, 1, 0);
      chk("skip_err", err, 1);

      // slow sweep: period 256 gives speed 0
      hold(8'h01, 256, 0);
      hold(8'h02, 256, 0);
      hold(8'h04, 1, 0);
      chk("slow_upd", update, 1);
      chk("slow_speed", speed, 0);
      hold(8'h04, 255, 0);
      hold(8'h08, 1, 0);
      chk("slow_upd2", update, 1);
      chk("slow_valid", valid, 1);
      base_e = n_err_seen;
      hold(8'h08, 509, 0);
      chk("sat_valid_before", valid, 1);
      hold(8'h08, 1, 0);
      chk("sat_valid", valid, 0);
      chk("sat_speed", speed, 0);
      chk("sat_errs", n_err_seen - base_e, 0);

      // re-track from SYNC with back-to-back steps, then reset during TRACK
      hold(8'h10, 1, 0);
      hold(8'h20, 1, 0);
      chk("fast_speed", speed, 255);
      chk("fast_valid", valid, 1);
      cyc(1'b1, 1'b1, 8'h40);
      chk("rstT_speed", speed, 0);
      chk("rstT_dir", dirLeft, 1);
      chk("rstT_pos", position, 0);
      chk("rstT_valid", valid, 0);
      chk("rstT_update", update, 0);
`ifdef LED_SWEEP_ERR_CNT_EN
      chk("rstT_errcount", errCount, 0);
`endif
      hold(8'h40, 3, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
